// File: rtl/byte_window_stats_pkg.sv
// Shared definitions for the byte_window_stats block: FSM encoding and default sizes.
package byte_window_stats_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_WIN    = 10;

endpackage

// File: rtl/byte_window_stats_if.sv
// Sample-in / result-out handshake bundle for byte_window_stats.
interface byte_window_stats_if #(
    parameter int DATA_W = byte_window_stats_pkg::DEF_DATA_W,
    parameter int WIN    = byte_window_stats_pkg::DEF_WIN,
    parameter int SUM_W  = DATA_W + $clog2(WIN),
    parameter int CNT_W  = $clog2(WIN + 1)
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_max;
    logic [CNT_W-1:0]  out_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_min, out_max, out_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_min, out_max, out_cnt
    );
endinterface

// File: rtl/byte_window_stats_win_acc_update.sv
// Next-value logic for the window accumulators; passes values through when no sample is accepted.
module byte_window_stats_win_acc_update #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 12,
    parameter int CNT_W  = 4
) (
    input  logic [SUM_W-1:0]  cur_sum,
    input  logic [DATA_W-1:0] cur_min,
    input  logic [DATA_W-1:0] cur_max,
    input  logic [CNT_W-1:0]  cur_cnt,
    input  logic [DATA_W-1:0] data,
    input  logic              accept,
    output logic [SUM_W-1:0]  nxt_sum,
    output logic [DATA_W-1:0] nxt_min,
    output logic [DATA_W-1:0] nxt_max,
    output logic [CNT_W-1:0]  nxt_cnt
);
    always_comb begin
        nxt_sum = cur_sum;
        nxt_min = cur_min;
        nxt_max = cur_max;
        nxt_cnt = cur_cnt;
        // data is only looked at under accept, so an idle X bus cannot leak into state
        if (accept) begin
            nxt_sum = cur_sum + SUM_W'(data);
            nxt_min = (data < cur_min) ? data : cur_min;
            nxt_max = (data > cur_max) ? data : cur_max;
            nxt_cnt = cur_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/byte_window_stats.sv
// Windowed sum/min/max/count over an 8-bit sample stream, with flush of partial windows
// and a held result port that backpressures the input while occupied.
module byte_window_stats
    import byte_window_stats_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WIN    = DEF_WIN,
    parameter int SUM_W  = DATA_W + $clog2(WIN),
    parameter int CNT_W  = $clog2(WIN + 1)
) (
    input logic                clk,
    input logic                rst_n,
    byte_window_stats_if.slave bus
);
    state_t            state;
    logic [SUM_W-1:0]  acc_sum;
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;
    logic [CNT_W-1:0]  acc_cnt;

    logic [SUM_W-1:0]  nxt_sum;
    logic [DATA_W-1:0] nxt_min;
    logic [DATA_W-1:0] nxt_max;
    logic [CNT_W-1:0]  nxt_cnt;
    logic              accept;
    logic              close;

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = (state == ST_HOLD);
    assign accept        = bus.in_valid & bus.in_ready;

    byte_window_stats_win_acc_update #(
        .DATA_W(DATA_W),
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_upd (
        .cur_sum(acc_sum),
        .cur_min(acc_min),
        .cur_max(acc_max),
        .cur_cnt(acc_cnt),
        .data   (bus.in_data),
        .accept (accept),
        .nxt_sum(nxt_sum),
        .nxt_min(nxt_min),
        .nxt_max(nxt_max),
        .nxt_cnt(nxt_cnt)
    );

    // Closing uses the post-accept count, so a flush on the WIN-th sample yields one window.
    assign close = (state == ST_ACCUM) &&
                   ((accept && (nxt_cnt == CNT_W'(WIN))) ||
                    (bus.flush && (nxt_cnt != '0)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_ACCUM;
            acc_sum     <= '0;
            acc_min     <= '1;
            acc_max     <= '0;
            acc_cnt     <= '0;
            bus.out_sum <= '0;
            bus.out_min <= '0;
            bus.out_max <= '0;
            bus.out_cnt <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (close) begin
                        bus.out_sum <= nxt_sum;
                        bus.out_min <= nxt_min;
                        bus.out_max <= nxt_max;
                        bus.out_cnt <= nxt_cnt;
                        acc_sum     <= '0;
                        acc_min     <= '1;
                        acc_max     <= '0;
                        acc_cnt     <= '0;
                        state       <= ST_HOLD;
                    end else begin
                        acc_sum <= nxt_sum;
                        acc_min <= nxt_min;
                        acc_max <= nxt_max;
                        acc_cnt <= nxt_cnt;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end
endmodule

// File: doc/byte_window_stats.md
Name: byte_window_stats

Overview:
- Consumer stage for the byte stream produced by the exp5 stimulus generator: 8-bit samples with a valid/ready handshake.
- Groups accepted samples into windows of WIN samples and reports sum, minimum, maximum and sample count for each window.
- Results leave through a registered valid/ready output port.
- A flush input closes a partial window early, so short streams still produce a result.

Parameters:
- DATA_W, 8, sample width in bits.
- WIN, 10, samples per full window (>=2).
- SUM_W, DATA_W+$clog2(WIN), sum width; 10 samples of 255 give 2550, which fits in 12 bits.
- CNT_W, $clog2(WIN+1), count width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  sample present.
- in_data  in  DATA_W  sample value, unsigned.
- in_ready  out  1  block can accept a sample this cycle.
- flush  in  1  one-cycle request to close the current partial window.
- out_valid  out  1  result registers hold a completed window.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  SUM_W  sum of window samples.
- out_min  out  DATA_W  minimum sample in window.
- out_max  out  DATA_W  maximum sample in window.
- out_cnt  out  CNT_W  number of samples in window (1..WIN).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=ACCUM.
  - Accumulators: sum=0, min=all-ones, max=0, cnt=0.
  - Outputs: out_valid=0, out_sum=0, out_min=0, out_max=0, out_cnt=0.
  - in_ready=1 from the first cycle after reset release.
  - Reset mid-window or mid-HOLD discards all partial and pending data with no output.
- States: ACCUM and HOLD.
  - in_ready = (state==ACCUM), combinational from state only.
  - out_valid = (state==HOLD), registered.
- ACCUM, accept = in_valid & in_ready:
  - sum += in_data, zero-extended.
  - min = min(min, in_data); max = max(max, in_data); cnt += 1.
- ACCUM, window close: the window closes when either condition holds.
  - Condition a: an accept makes cnt reach WIN.
  - Condition b: flush=1 and the count including any same-cycle accept is >=1.
  - On close, the output registers load final values (including the same-cycle sample), the accumulators clear, and the state goes to HOLD.
  - Latency: out_valid rises one cycle after the closing accept or flush.
- Flush edge cases:
  - flush with cnt=0 and no accept is a no-op.
  - flush coinciding with the WIN-th sample yields one window of WIN samples, not two.
- HOLD:
  - Output registers stay stable and in_ready=0 (backpressure to the stimulus).
  - On out_ready=1: state returns to ACCUM; out_valid=0 and in_ready=1 on the next cycle. There is no same-cycle bypass.
  - flush is ignored in HOLD.
  - out_* data holds its last value after the handshake, until the next load.
- Arithmetic: unsigned throughout; no overflow is possible by construction of SUM_W.
- X safety: in_data is don't-care when in_valid=0 and must not affect any state.

Decomposition:
- Shared header (exp5_defs.vh):
  - State encodings ST_ACCUM=1'b0, ST_HOLD=1'b1.
  - Default DATA_W and WIN.
- One natural sub-module, win_acc_update: combinational next-value logic for sum, min, max and cnt given the current accumulators, the sample and the accept strobe. It is reused for the same-cycle-close path.
- FSM and output registers live in the top.

Test Plan:
- Full window: samples 0..9 with in_valid held, out_ready=1 → one result with sum=45, min=0, max=9, cnt=10; out_valid for exactly 1 cycle; in_ready low for exactly 1 cycle.
- Saturation width: ten samples of 255 → sum=2550 (12'h9F6), min=max=255, cnt=10.
- Backpressure: complete a window with out_ready=0 for 3 cycles → out_* stable, in_ready=0 throughout, offered samples not consumed; out_ready=1 → in_ready=1 next cycle, and the first held sample lands in the new window.
- Flush partial: samples 200, 17, 255, then flush → sum=472, min=17, max=255, cnt=3. A second flush with cnt=0 produces no output.
- Flush coincident with accept: 4 samples of 5, then sample 7 with flush in the same cycle → sum=27, min=5, max=7, cnt=5; exactly one result.
- Reset mid-operation:
  - rst_n=0 for 1 cycle after 6 samples → no result emitted; the next 10 samples 1..10 give sum=55, min=1, max=10.
  - Reset during HOLD clears out_valid on the next cycle.
